// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio frame sequencer.
package audio_pkg;

  // Reference sample width for the stereo frame record.
  localparam int STEREO_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    PROC,
    WAIT_OUT,
    WRITE
  } seq_state_t;

  typedef struct packed {
    logic [STEREO_W-1:0] l;
    logic [STEREO_W-1:0] r;
  } stereo_t;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/audio_sample_sequencer_if.sv
// Codec FIFO and effects-chain handshake bundle.
// master: the sequencer. slave: codec driver plus effects datapath.
interface audio_sample_sequencer_if #(
  parameter int DATA_W = 32
);
  // Codec input FIFO
  logic              audio_in_available;
  logic [DATA_W-1:0] audio_in_L;
  logic [DATA_W-1:0] audio_in_R;
  logic              read_audio_in;
  // Codec output FIFO
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [DATA_W-1:0] audio_out_L;
  logic [DATA_W-1:0] audio_out_R;
  // Effects chain
  logic              proc_start;
  logic [DATA_W-1:0] proc_in_L;
  logic [DATA_W-1:0] proc_in_R;
  logic              res_valid;
  logic [DATA_W-1:0] res_L;
  logic [DATA_W-1:0] res_R;

  modport master (
    input  audio_in_available, audio_in_L, audio_in_R,
    output read_audio_in,
    input  audio_out_allowed,
    output write_audio_out, audio_out_L, audio_out_R,
    output proc_start, proc_in_L, proc_in_R,
    input  res_valid, res_L, res_R
  );

  modport slave (
    output audio_in_available, audio_in_L, audio_in_R,
    input  read_audio_in,
    output audio_out_allowed,
    input  write_audio_out, audio_out_L, audio_out_R,
    input  proc_start, proc_in_L, proc_in_R,
    output res_valid, res_L, res_R
  );

endinterface

// File: rtl/audio_sample_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter
  import audio_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  // Count register: clear, else saturating increment.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= WIDTH'(sat_inc(32'(count), 32'(MAX_COUNT)));
    end
  end

endmodule

// File: rtl/audio_sample_sequencer.sv
// Frame sequencer: pops one stereo frame from the codec input FIFO, runs it
// through the effects chain (or bypasses it), and pushes the result to the
// codec output FIFO. Exposes saturating frame/timeout counters for debug.
module audio_sample_sequencer
  import audio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       bypass,
  audio_sample_sequencer_if.master   bus,
  output logic                       busy,
  output logic [CNT_W-1:0]           frame_count,
  output logic [CNT_W-1:0]           timeout_count
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  seq_state_t        state;
  logic              byp_q;
  logic              read_q, start_q, write_q;
  logic [DATA_W-1:0] proc_l_q, proc_r_q;
  logic [DATA_W-1:0] out_l_q, out_r_q;

  logic [TO_W-1:0]   to_cnt;
  logic              to_hit, to_clr, to_inc;
  logic              frame_inc, timeout_inc;

  assign bus.read_audio_in   = read_q;
  assign bus.proc_start      = start_q;
  assign bus.write_audio_out = write_q;
  assign bus.proc_in_L       = proc_l_q;
  assign bus.proc_in_R       = proc_r_q;
  assign bus.audio_out_L     = out_l_q;
  assign bus.audio_out_R     = out_r_q;

  // PROC cycle counter is zeroed during READ, so the first PROC cycle sees 0.
  assign to_hit      = (to_cnt == TO_LAST);
  assign to_clr      = (state == READ);
  assign to_inc      = (state == PROC) && !byp_q;
  // A result arriving on the timeout cycle takes priority and is not a timeout.
  assign timeout_inc = (state == PROC) && to_hit && !bus.res_valid;
  assign frame_inc   = (state == WRITE);

  sat_counter #(.WIDTH(TO_W)) u_proc_timer (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .clr   (to_clr),
    .inc   (to_inc),
    .count (to_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .clr   (1'b0),
    .inc   (frame_inc),
    .count (frame_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .clr   (1'b0),
    .inc   (timeout_inc),
    .count (timeout_count)
  );

  // Frame FSM with registered strobes and data outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      byp_q    <= 1'b0;
      busy     <= 1'b0;
      read_q   <= 1'b0;
      start_q  <= 1'b0;
      write_q  <= 1'b0;
      // NOTE: data registers are reset too because they drive ports that
      // must read 0 after reset; pure storage arrays would be left unreset.
      proc_l_q <= '0;
      proc_r_q <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      read_q  <= 1'b0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && bus.audio_in_available) begin
            state  <= READ;
            read_q <= 1'b1;
            busy   <= 1'b1;
          end
        end
        READ: begin
          // Head of FIFO is still this frame; the pop lands at this edge.
          proc_l_q <= bus.audio_in_L;
          proc_r_q <= bus.audio_in_R;
          byp_q    <= bypass;
          if (bypass) begin
            out_l_q <= bus.audio_in_L;
            out_r_q <= bus.audio_in_R;
            state   <= WAIT_OUT;
          end else begin
            start_q <= 1'b1;
            state   <= PROC;
          end
        end
        PROC: begin
          if (bus.res_valid) begin
            out_l_q <= bus.res_L;
            out_r_q <= bus.res_R;
            state   <= WAIT_OUT;
          end else if (to_hit) begin
            // Effects never answered: pass the dry frame through.
            out_l_q <= proc_l_q;
            out_r_q <= proc_r_q;
            state   <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          // Hold here as long as the output FIFO is full.
          if (bus.audio_out_allowed) begin
            write_q <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/audio_sample_sequencer.md
# audio_sample_sequencer

Frame-level controller between the audio codec driver's FIFO handshake (`audio_in_available`/`read_audio_in`, `audio_out_allowed`/`write_audio_out`) and the effects datapath. It pops one stereo frame from the input FIFO and launches the effect chain on it. It waits for the processed result, or bypasses on timeout or on request, and pushes the result to the output FIFO. It sits in the board wrapper in place of the direct read/write request wiring, and exposes frame and timeout counters for debug display.

## Interface
- `DATA_W`, 32, sample width per channel
- `TIMEOUT_CYC`, 1024, max cycles allowed in PROC before forced bypass (≥2)
- `CNT_W`, 16, width of saturating debug counters
- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `enable`  in  1  allow new frames to start
- `bypass`  in  1  skip effect chain (sampled at READ)
- `audio_in_available`  in  1  driver input FIFO non-empty
- `audio_in_L`, `audio_in_R`  in  DATA_W  driver head-of-FIFO samples
- `read_audio_in`  out  1  one-cycle pop strobe
- `audio_out_allowed`  in  1  driver output FIFO has space
- `write_audio_out`  out  1  one-cycle push strobe
- `audio_out_L`, `audio_out_R`  out  DATA_W  registered output samples
- `proc_start`  out  1  one-cycle launch to effects
- `proc_in_L`, `proc_in_R`  out  DATA_W  captured frame, held until next READ
- `res_valid`  in  1  effects result strobe
- `res_L`, `res_R`  in  DATA_W  effects result
- `busy`  out  1  state ≠ IDLE
- `frame_count`  out  CNT_W  frames written, saturating
- `timeout_count`  out  CNT_W  timeouts, saturating

## Operation
- States: IDLE, READ, PROC, WAIT_OUT, WRITE.
- IDLE → READ when `enable && audio_in_available`.
- READ (1 cycle):
  - `read_audio_in=1`.
  - Capture `audio_in_L/R` into `proc_in_L/R`.
  - Latch `bypass` into `byp_q`.
  - Next state is WAIT_OUT if `bypass`, else PROC.
  - If bypassing, also load `audio_out_L/R` with the captured frame.
- PROC:
  - `proc_start=1` in the first cycle only; timeout counter cleared on entry.
  - On `res_valid`: load `audio_out_L/R ← res_L/R`, go to WAIT_OUT.
  - If the counter reaches TIMEOUT_CYC−1 without `res_valid`: load `audio_out_L/R ← proc_in_L/R`, increment `timeout_count`, go to WAIT_OUT.
  - `res_valid` on the same cycle as the timeout wins (result used, no timeout counted).
- WAIT_OUT → WRITE when `audio_out_allowed`; otherwise hold indefinitely. No frames are dropped; backpressure propagates to the input FIFO.
- WRITE (1 cycle): `write_audio_out=1`, `frame_count++`, next state IDLE.
- `res_valid` outside PROC is ignored.
- Deasserting `enable` mid-frame completes the current frame; the block then stays in IDLE.
- Counters saturate at 2^CNT_W−1.
- Reset (async assert, release synchronous to `CLOCK_50`):
  - State IDLE.
  - All strobes 0, all data outputs 0, counters 0, `busy` 0.
  - Reset mid-frame abandons the frame with no strobe emitted.

## Timing
- All outputs are registered; strobes are high exactly one cycle per frame.
- Frame N fastest path, effects case, with `audio_in_available` seen in IDLE at cycle t:
  - READ at t+1.
  - PROC at t+2 (`proc_start`).
  - Earliest `res_valid` at t+3.
  - WAIT_OUT at t+4.
  - WRITE at t+5 if `audio_out_allowed` is high at t+4.
- Bypass path: READ t+1, WAIT_OUT t+2, WRITE t+3.
- Back-to-back frames: IDLE is occupied ≥1 cycle between frames, so the minimum period is 6 cycles (effects) or 4 cycles (bypass).
- `audio_out_L/R` are stable from WAIT_OUT entry through the WRITE cycle.
- `proc_in_L/R` are stable from READ+1 until the next READ.

## Structure
- Package `audio_pkg`:
  - `typedef enum logic [2:0] seq_state_t {IDLE, READ, PROC, WAIT_OUT, WRITE}`.
  - `typedef struct packed { logic [DATA_W-1:0] l, r; } stereo_t` with default DATA_W=32.
  - Saturating-increment function.
- One natural sub-module: `sat_counter` (parameter width, inputs `inc`/`clr`), instantiated for `frame_count`, `timeout_count` and the PROC timeout.
- FSM and datapath registers stay in the top module.

## Test plan
- Normal frame:
  - Stimulus: in = (0x0000_1111, 0x0000_2222); effects reply `res_valid` 3 cycles after `proc_start` with (0xAAAA, 0xBBBB); `audio_out_allowed`=1.
  - Required: exactly one `read_audio_in`, one `proc_start`, and one `write_audio_out`; out = (0xAAAA, 0xBBBB); `frame_count`=1.
- Bypass:
  - Stimulus: `bypass`=1, in = (5, 6).
  - Required: no `proc_start`; `write_audio_out` 3 cycles after the IDLE cycle; out = (5, 6).
- Timeout:
  - Stimulus: TIMEOUT_CYC=8, no `res_valid`.
  - Required: WAIT_OUT is entered 8 cycles after PROC entry; out = input; `timeout_count`=1.
  - Follow-up: `res_valid` arriving later, in IDLE, is ignored.
- Backpressure:
  - Stimulus: hold `audio_out_allowed`=0 for 50 cycles.
  - Required: no write and no second read while held; WRITE occurs 1 cycle after `allowed` rises.
- Reset mid-PROC:
  - Stimulus: assert `reset_n`=0 in PROC.
  - Required: all outputs and counters are 0 immediately; after release the next frame behaves as in scenario 1.
- Stream:
  - Stimulus: 100 frames back-to-back with the effects delay randomized 1–5 cycles.
  - Required: outputs are in order with no duplication; `frame_count`=100.
